baud_frame_timer: RTL and testbench

- Parametrised successor to the UART bit-time counter.
- Latches a programmable baud divisor and frame length on a start pulse, then runs a bit-time counter.
- Emits one btu (bit time up) strobe per bit period, tracks the current bit index, and pulses done after the last bit.
- Sits between the UART TX/RX control FSMs and the baud-select register. Those FSMs no longer hold their own bit counters.

---
 rtl/baud_frame_timer.sv | 108 ++++++++++
 tb/tb_baud_frame_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_frame_timer.sv
// baud_frame_timer: bit-time counter for the UART TX/RX control FSMs.
// Latches a baud divisor and frame length on start. It then emits one btu
// strobe per bit period (baud+1 clk cycles), tracks the 0-based bit index,
// and pulses done for one cycle after the final bit of a completed frame.
// Optional feature macro: BAUD_MID_TICK_EN adds the mid-bit strobe output 'mid'.
module baud_frame_timer #(
   parameter int CNT_W = 19,
   parameter int NB_W  = 4
) (
   input  logic             clk,
   input  logic             reset,   // asynchronous, active-low
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] baud,
   input  logic [NB_W-1:0]  nbits,
   output logic             busy,
   output logic             btu,
   output logic [NB_W-1:0]  bit_idx,
   output logic             done
`ifdef BAUD_MID_TICK_EN
   ,
   output logic             mid
`endif
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [CNT_W-1:0] q;
   logic [CNT_W-1:0] baud_l;
   logic [NB_W-1:0]  nbits_l;
   logic             last_bit;

   // A latched frame length of 0 runs as a single bit period.
   always_comb begin
      last_bit = 1'b0;
      if (nbits_l == '0)
         last_bit = (bit_idx == '0);
      else
         last_bit = (bit_idx == nbits_l - NB_W'(1));
   end

   // The bit-period strobe fires on the final cycle of each period, only while running.
   always_comb begin
      btu = (state == S_RUN) && (q == baud_l);
   end

`ifdef BAUD_MID_TICK_EN
   // Mid-bit sampling point for the receiver. It coincides with btu when baud_l is 0.
   always_comb begin
      mid = (state == S_RUN) && (q == (baud_l >> 1));
   end
`endif

   assign busy = (state == S_RUN);

   // Frame FSM, bit-time counter, bit index, latched configuration and done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         q       <= '0;
         bit_idx <= '0;
         baud_l  <= '0;
         nbits_l <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               q       <= '0;
               bit_idx <= '0;
               // When abort and start arrive together, abort wins and the start is dropped.
               if (start && !abort) begin
                  state   <= S_RUN;
                  baud_l  <= baud;
                  nbits_l <= nbits;
               end
            end
            S_RUN: begin
               // Abort takes priority over a coincident btu, so done is never raised on abort.
               if (abort) begin
                  state   <= S_IDLE;
                  q       <= '0;
                  bit_idx <= '0;
               end else if (btu) begin
                  q <= '0;
                  if (last_bit) begin
                     state   <= S_IDLE;
                     bit_idx <= '0;
                     done    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + NB_W'(1);
                  end
               end else begin
                  q <= q + CNT_W'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               q       <= '0;
               bit_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_baud_frame_timer.sv
// Scoreboard bench for baud_frame_timer. The stimulus tasks push the expected
// mid/btu/done events, each tagged with its cycle and bit index. A monitor
// process pops the queue and compares whenever the DUT raises a strobe.
module tb_baud_frame_timer;

   localparam int CNT_W = 19;
   localparam int NB_W  = 4;

   localparam int unsigned K_MID  = 1;
   localparam int unsigned K_BTU  = 2;
   localparam int unsigned K_DONE = 3;

   typedef struct {
      int unsigned kind;
      int unsigned cyc;
      int unsigned idx;
   } ev_t;

   logic             clk;
   logic             reset;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] baud;
   logic [NB_W-1:0]  nbits;
   logic             busy;
   logic             btu;
   logic [NB_W-1:0]  bit_idx;
   logic             done;
`ifdef BAUD_MID_TICK_EN
   logic             mid;
`endif

   int unsigned cyc;
   int unsigned checks;
   int unsigned failures;
   ev_t         exp_q[$];

   baud_frame_timer #(.CNT_W(CNT_W), .NB_W(NB_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .baud    (baud),
      .nbits   (nbits),
      .busy    (busy),
      .btu     (btu),
      .bit_idx (bit_idx),
      .done    (done)
`ifdef BAUD_MID_TICK_EN
      ,
      .mid     (mid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint unsigned pack_ev(int unsigned kind, int unsigned c, int unsigned idx);
      return {8'(kind), 40'(c), 16'(idx)};
   endfunction

   // Compare one DUT strobe against the head of the scoreboard.
   task automatic observe(input int unsigned kind, input int unsigned idx);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event: actual kind=%0d cycle=%0d idx=%0d expected none", kind, cyc, idx);
      end else begin
         e = exp_q.pop_front();
         chk("event{kind,cycle,idx}", pack_ev(kind, cyc, idx), pack_ev(e.kind, e.cyc, e.idx));
      end
   endtask

   // Monitor: samples on the falling edge, flags missed events, then checks the strobes raised.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         checks++;
         failures++;
         $display("FAIL missed_event: actual none expected kind=%0d cycle=%0d idx=%0d",
                  exp_q[0].kind, exp_q[0].cyc, exp_q[0].idx);
         void'(exp_q.pop_front());
      end
`ifdef BAUD_MID_TICK_EN
      if (mid === 1'b1) observe(K_MID, 32'(bit_idx));
`endif
      if (btu === 1'b1) observe(K_BTU, 32'(bit_idx));
      if (done === 1'b1) observe(K_DONE, 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int unsigned c);
      while (cyc < c) tick();
   endtask

   // Expected events for the first nb bit periods of a frame accepted in cycle c0.
   task automatic push_bits(input int unsigned c0, input int unsigned b, input int unsigned nb,
                            input bit with_done);
      int unsigned base;
      for (int unsigned i = 0; i < nb; i++) begin
         base = c0 + 1 + i * (b + 1);
`ifdef BAUD_MID_TICK_EN
         exp_q.push_back('{K_MID, base + b / 2, i});
`endif
         exp_q.push_back('{K_BTU, base + b, i});
      end
      if (with_done) exp_q.push_back('{K_DONE, c0 + nb * (b + 1) + 1, 0});
   endtask

   // Raw start pulse lasting one cycle. The caller is at the start of a cycle.
   task automatic pulse_start(input int unsigned b, input int unsigned n);
      baud  = CNT_W'(b);
      nbits = NB_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic start_frame(input int unsigned b, input int unsigned n, output int unsigned c0);
      c0 = cyc;
      push_bits(c0, b, (n == 0) ? 1 : n, 1'b1);
      pulse_start(b, n);
   endtask

   task automatic drain(input int unsigned limit);
      int unsigned t;
      t = 0;
      while (exp_q.size() > 0 && t < limit) begin
         tick();
         t++;
      end
      tick();
      tick();
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   int unsigned c0;
   int unsigned c1;

   initial begin
      cyc      = 0;
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      baud     = '0;
      nbits    = '0;

      // Reset state, then idle with start low.
      tick();
      tick();
      chk("rst_outputs{busy,btu,done,idx}", {busy, btu, done, bit_idx}, 0);
      reset = 1'b1;
      tick();
      chk("post_rst_outputs{busy,btu,done,idx}", {busy, btu, done, bit_idx}, 0);
      repeat (100) tick();
      chk("idle_busy", busy, 0);

      // baud=4, nbits=3: btu at +5/+10/+15 and done at +16.
      start_frame(4, 3, c0);
      chk("t2_busy_first", busy, 1);
      chk("t2_idx_first", bit_idx, 0);
      wait_to(c0 + 15);
      chk("t2_busy_last", busy, 1);
      wait_to(c0 + 16);
      chk("t2_busy_done_cycle", busy, 0);
      drain(50);

      // baud=0, nbits=0 gives a single 1-cycle bit. A start in the done cycle is accepted.
      start_frame(0, 0, c0);
      tick();
      start_frame(2, 2, c1);
      chk("t3_restart_cycle", c1 - c0, 2);
      chk("t3_busy_restart", busy, 1);
      drain(50);

      // A start and a baud change while busy are ignored.
      start_frame(9, 8, c0);
      wait_to(c0 + 4);
      pulse_start(3, 2);
      baud = CNT_W'(3);
      drain(120);

      // Abort on the cycle of the 2nd btu: idle next cycle, no done.
      c0 = cyc;
      push_bits(c0, 9, 2, 1'b0);
      pulse_start(9, 8);
      wait_to(c0 + 20);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_idx", bit_idx, 0);
      repeat (30) tick();
      chk("t5_no_done", exp_q.size(), 0);

      // Start together with abort in idle is dropped.
      abort = 1'b1;
      pulse_start(2, 1);
      abort = 1'b0;
      chk("t5_abort_start_busy", busy, 0);
      repeat (10) tick();

      // Reset mid-frame clears immediately, and nothing follows until a new start.
      c0 = cyc;
      push_bits(c0, 9, 1, 1'b0);
      pulse_start(9, 8);
      wait_to(c0 + 12);
      reset = 1'b0;
      #1;
      chk("t6_rst_async{busy,btu,done,idx}", {busy, btu, done, bit_idx}, 0);
      tick();
      reset = 1'b1;
      repeat (100) tick();
      chk("t6_no_events", exp_q.size(), 0);
      chk("t6_busy", busy, 0);

      // Mid-bit strobe placement: mid and btu coincide when baud is 0.
      start_frame(9, 2, c0);
      drain(50);
      start_frame(0, 2, c0);
      drain(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
